counting_register: RTL
======================

Name: counting_register

Overview:
Parametrised successor to the 8-bit load/increment/clear register used by the MBC datapath (program counter, address and general counters). It adds width and reset-value parameters, decrement, a programmable step, an upper limit, wrap or saturate mode, and registered status flags. It sits directly in the datapath and is driven by control-unit strobes.

Parameters:
WIDTH, 8, data width in bits (legal range 2..32).
RESET_VALUE, 0, value loaded into OUTPUT_DATA by RESET and by CLEAR; must be <= 2^WIDTH-1.
SATURATE, 0, overflow mode: 0 = wrap, 1 = clamp at bound.

Ports:
CLOCK  input  1  rising-edge clock.
RESET  input  1  asynchronous, active-high reset.
CLEAR  input  1  synchronous clear to RESET_VALUE.
WRITE_ENABLE  input  1  synchronous load of INPUT_DATA.
INCREMENT  input  1  add STEP this cycle.
DECREMENT  input  1  subtract STEP this cycle.
STEP  input  WIDTH  step magnitude; 0 means hold.
LIMIT  input  WIDTH  inclusive upper bound for counting.
INPUT_DATA  input  WIDTH  load value.
OUTPUT_DATA  output  WIDTH  register contents.
ZERO  output  1  registered flag, OUTPUT_DATA == 0.
AT_LIMIT  output  1  registered flag, OUTPUT_DATA == LIMIT.
WRAPPED  output  1  one-cycle pulse: the last update crossed a bound.

Behaviour:
- Reset (RESET high, asynchronous): OUTPUT_DATA = RESET_VALUE, ZERO = (RESET_VALUE == 0), AT_LIMIT = 0, WRAPPED = 0.
  - Effective immediately; any in-progress update is discarded.
  - Release takes effect at the next rising edge.
- Operation priority per rising edge:
  - CLEAR > WRITE_ENABLE > count.
  - Count applies only when exactly one of INCREMENT/DECREMENT is high.
  - INCREMENT and DECREMENT both high: hold.
  - All strobes low: hold.
- CLEAR: OUTPUT_DATA <= RESET_VALUE; WRAPPED <= 0.
- WRITE_ENABLE: OUTPUT_DATA <= INPUT_DATA, loaded verbatim even if > LIMIT; WRAPPED <= 0.
- Increment (compute in WIDTH+1 bits, sum = OUTPUT_DATA + STEP):
  - sum <= LIMIT: OUTPUT_DATA <= sum, WRAPPED <= 0.
  - sum > LIMIT, SATURATE = 0: OUTPUT_DATA <= sum - LIMIT - 1 (modulo LIMIT+1), WRAPPED <= 1. With LIMIT = all-ones this is plain modulo-2^WIDTH wrap.
  - sum > LIMIT, SATURATE = 1: OUTPUT_DATA <= LIMIT, WRAPPED <= 1.
- Decrement (borrow from WIDTH+1-bit subtract):
  - STEP <= OUTPUT_DATA: OUTPUT_DATA <= OUTPUT_DATA - STEP, WRAPPED <= 0.
  - Borrow, SATURATE = 0: OUTPUT_DATA <= LIMIT + 1 - (STEP - OUTPUT_DATA), WRAPPED <= 1.
  - Borrow, SATURATE = 1: OUTPUT_DATA <= 0, WRAPPED <= 1.
- Out-of-range start value: if OUTPUT_DATA > LIMIT when a count is applied, the first count forces OUTPUT_DATA to 0 on increment (LIMIT if SATURATE = 1), or to LIMIT on decrement, with WRAPPED <= 1.
- STEP > LIMIT+1: result is implementation-defined but must stay within 0..LIMIT; the bench only checks the range.
- Flags:
  - ZERO and AT_LIMIT are computed from the next-state value and registered, so they are coherent with OUTPUT_DATA in the same cycle. No combinational path from inputs to outputs.
  - WRAPPED is high for exactly one cycle per crossing and deasserts on the following hold.
- Latency: one clock from strobe to OUTPUT_DATA and flags.
- Mid-operation behaviour:
  - LIMIT changes take effect on the next count.
  - LIMIT is not applied on hold, CLEAR, or load.

Test Plan:
1. WIDTH=8, RESET_VALUE=0x10: assert RESET between clock edges -> OUTPUT_DATA=0x10 immediately; ZERO=0, WRAPPED=0.
2. LIMIT=0xFF, STEP=1: load 0xFE; INCREMENT for 2 cycles -> 0xFF (AT_LIMIT=1), then 0x00 (ZERO=1, WRAPPED=1 for exactly 1 cycle).
3. SATURATE=1, LIMIT=0x09, STEP=3: start at 0; INCREMENT for 5 cycles -> 3, 6, 9, 9, 9; WRAPPED=1 on cycles 4 and 5. Then DECREMENT with STEP=4 -> 5, 1, 0 (WRAPPED=1 on the final step).
4. SATURATE=0, LIMIT=9, STEP=4: start at 2, DECREMENT -> 8, WRAPPED=1. Start at 8, INCREMENT -> 2, WRAPPED=1.
5. Priority: CLEAR, WRITE_ENABLE (INPUT_DATA=0x55) and INCREMENT all high -> RESET_VALUE. Then WRITE_ENABLE+INCREMENT -> 0x55. Then INCREMENT+DECREMENT -> hold at 0x55.
6. Load 0x20 with LIMIT=0x0F -> OUTPUT_DATA=0x20. Then INCREMENT -> 0x00 with WRAPPED=1. Finally, assert RESET during an active INCREMENT -> RESET_VALUE with no further count applied.

Source files
------------

// File: rtl/counting_register_if.sv
// Control/status bundle between the control unit and a counting_register.
// The control unit drives strobes and operands; the register returns contents and flags.
interface counting_register_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clear;
    logic             write_enable;
    logic             increment;
    logic             decrement;
    logic [WIDTH-1:0] step;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] input_data;
    logic [WIDTH-1:0] output_data;
    logic             zero;
    logic             at_limit;
    logic             wrapped;

    modport master (
        output clear, write_enable, increment, decrement, step, limit, input_data,
        input  output_data, zero, at_limit, wrapped
    );

    modport slave (
        input  clear, write_enable, increment, decrement, step, limit, input_data,
        output output_data, zero, at_limit, wrapped
    );
endinterface

// File: rtl/counting_register.sv
// Load/increment/decrement/clear register with programmable step, inclusive upper limit,
// wrap or saturate on overflow, and registered ZERO/AT_LIMIT/WRAPPED status.
module counting_register #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter bit          SATURATE    = 1'b0
) (
    input logic                 clk_i,
    input logic                 rst_i,
    counting_register_if.slave  bus_io
);
    localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    logic             at_limit_q, at_limit_d;
    logic             wrapped_q, wrapped_d;

    logic [WIDTH:0] cur_ext, step_ext, lim_ext, lim_p1;
    logic [WIDTH:0] sum, wrap_up, deficit, wrap_dn;

    always_comb begin
        cur_ext  = {1'b0, data_q};
        step_ext = {1'b0, bus_io.step};
        lim_ext  = {1'b0, bus_io.limit};
        lim_p1   = lim_ext + 1'b1;
        sum      = cur_ext + step_ext;
        wrap_up  = sum - lim_p1;
        deficit  = step_ext - cur_ext;
        wrap_dn  = lim_p1 - deficit;
    end

    always_comb begin
        data_d    = data_q;
        wrapped_d = 1'b0;
        if (bus_io.clear) begin
            data_d = ResetVal;
        end else if (bus_io.write_enable) begin
            data_d = bus_io.input_data;
        end else if (bus_io.increment && !bus_io.decrement) begin
            if (data_q > bus_io.limit) begin
                data_d    = SATURATE ? bus_io.limit : '0;
                wrapped_d = 1'b1;
            end else if (sum <= lim_ext) begin
                data_d = sum[WIDTH-1:0];
            end else begin
                wrapped_d = 1'b1;
                if (SATURATE) begin
                    data_d = bus_io.limit;
                end else if (wrap_up <= lim_ext) begin
                    data_d = wrap_up[WIDTH-1:0];
                end else begin
                    // Step larger than the whole range: park at 0 to stay in bounds.
                    data_d = '0;
                end
            end
        end else if (bus_io.decrement && !bus_io.increment) begin
            if (data_q > bus_io.limit) begin
                data_d    = bus_io.limit;
                wrapped_d = 1'b1;
            end else if (bus_io.step <= data_q) begin
                data_d = data_q - bus_io.step;
            end else begin
                wrapped_d = 1'b1;
                if (!SATURATE && (deficit <= lim_p1)) begin
                    data_d = wrap_dn[WIDTH-1:0];
                end else begin
                    data_d = '0;
                end
            end
        end
        zero_d     = (data_d == '0);
        at_limit_d = (data_d == bus_io.limit);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q     <= ResetVal;
            zero_q     <= (ResetVal == '0);
            at_limit_q <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            data_q     <= data_d;
            zero_q     <= zero_d;
            at_limit_q <= at_limit_d;
            wrapped_q  <= wrapped_d;
        end
    end

    assign bus_io.output_data = data_q;
    assign bus_io.zero        = zero_q;
    assign bus_io.at_limit    = at_limit_q;
    assign bus_io.wrapped     = wrapped_q;
endmodule
